// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the command FIFO sequencer: state encoding,
// command address field position and the default NOP address.
package cmd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT     = 2'd1,
      DISPATCH = 2'd2,
      GAP      = 2'd3
   } seq_state_e;

   localparam logic [11:0] DEFAULT_NOP_ADDRESS = 12'hFFF;
   localparam int          ADDR_MSB            = 15;
   localparam int          ADDR_LSB            = 4;
   localparam int          CNT_W               = 4;

   // A command word whose address field matches nop_addr carries no command.
   function automatic logic is_nop(input logic [15:0] word, input logic [11:0] nop_addr);
      return (word[ADDR_MSB:ADDR_LSB] == nop_addr);
   endfunction

endpackage

// File: rtl/cmd_seq_down_counter.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement, and decrement stops at zero.
module cmd_seq_down_counter
   import cmd_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   assign zero_o = (count_q == '0);

   // Next count: load, else decrement while non-zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && !zero_o) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/command_fifo_sequencer.sv
// Command FIFO sequencer: pops one 16-bit command word at a time, waits
// out the FIFO read latency, strobes the word to the command decoders
// (NOP words are dropped with a NopSeen pulse) and then enforces an idle
// gap before the next pop.
// Optional build macro CMD_SEQ_COUNTER_EN adds the DispatchCount output.
//
// FIFO handshake: FifoRdEn is a one-cycle pop request, raised only in
// IDLE while FifoEmpty=0 and Hold=0; the word it pops is taken from
// FifoDout exactly FIFO_READ_LATENCY cycles later. Only one pop is ever
// outstanding because the FSM leaves IDLE in the same cycle as the pop.
module command_fifo_sequencer
   import cmd_seq_pkg::*;
#(
   parameter int          FIFO_READ_LATENCY = 1,
   parameter int          CMD_GAP           = 2,
   parameter logic [11:0] NOP_ADDRESS       = DEFAULT_NOP_ADDRESS
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        FifoEmpty,
   input  logic [15:0] FifoDout,
   input  logic        Hold,
   output logic        FifoRdEn,
   output logic        CommandFifoReadEn,
   output logic [15:0] COMMAND_WORD,
   output logic        Busy,
   output logic        NopSeen,
`ifdef CMD_SEQ_COUNTER_EN
   output logic [15:0] DispatchCount,
`endif
   output seq_state_e  DbgState
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FIFO_READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = (CMD_GAP > 0) ? CNT_W'(CMD_GAP - 1) : '0;

   seq_state_e  state_q;
   logic        strobe_q;
   logic        nop_q;
   logic [15:0] cmd_word_q;
   logic        pop;
   logic        lat_zero;
   logic        gap_zero;

   // A pop is never issued while reset is held, so no word is lost to it.
   assign pop               = (state_q == IDLE) && !FifoEmpty && !Hold && !reset;
   assign FifoRdEn          = pop;
   assign Busy              = (state_q != IDLE);
   assign CommandFifoReadEn = strobe_q;
   assign NopSeen           = nop_q;
   assign COMMAND_WORD      = cmd_word_q;
   assign DbgState          = state_q;

   cmd_seq_down_counter u_lat_cnt (
      .clk_i      (Clk),
      .rst_i      (reset),
      .load_i     (pop),
      .load_val_i (LAT_LOAD),
      .dec_i      (state_q == WAIT),
      .zero_o     (lat_zero)
   );

   cmd_seq_down_counter u_gap_cnt (
      .clk_i      (Clk),
      .rst_i      (reset),
      .load_i     (state_q == DISPATCH),
      .load_val_i (GAP_LOAD),
      .dec_i      (state_q == GAP),
      .zero_o     (gap_zero)
   );

   // Sequencer FSM; the strobe, NOP pulse and word are registered so they
   // all appear together in the DISPATCH cycle.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q    <= IDLE;
         strobe_q   <= 1'b0;
         nop_q      <= 1'b0;
         cmd_word_q <= 16'h0000;
      end else begin
         strobe_q <= 1'b0;
         nop_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (lat_zero) begin
                  state_q <= DISPATCH;
                  if (is_nop(FifoDout, NOP_ADDRESS)) begin
                     nop_q <= 1'b1;
                  end else begin
                     cmd_word_q <= FifoDout;
                     strobe_q   <= 1'b1;
                  end
               end
            end
            DISPATCH: begin
               state_q <= (CMD_GAP == 0) ? IDLE : GAP;
            end
            GAP: begin
               if (gap_zero) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CMD_SEQ_COUNTER_EN
   logic [15:0] dispatch_cnt_q;

   // Count real dispatches, saturating at all-ones.
   always_ff @(posedge Clk) begin
      if (reset) begin
         dispatch_cnt_q <= 16'h0000;
      end else if (strobe_q && (dispatch_cnt_q != 16'hFFFF)) begin
         dispatch_cnt_q <= dispatch_cnt_q + 16'd1;
      end
   end

   assign DispatchCount = dispatch_cnt_q;
`endif

endmodule

// File: tb/tb_command_fifo_sequencer.sv
// Directed bench for command_fifo_sequencer: instance A (latency 1, gap 2)
// and instance B (latency 3, gap 0), each fed by a small FIFO model.
module tb_command_fifo_sequencer;
   import cmd_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic        reset;
   logic        hold_a, hold_b;
   logic        empty_a, empty_b;
   logic [15:0] dout_a, dout_b;
   logic        rd_a, rd_b, stb_a, stb_b, busy_a, busy_b, nop_a, nop_b;
   logic [15:0] word_a, word_b;
   seq_state_e  st_a, st_b;
`ifdef CMD_SEQ_COUNTER_EN
   logic [15:0] cnt_a, cnt_b;
`endif

   logic [15:0] fq_a[$];
   logic [15:0] fq_b[$];
   logic [15:0] pipe_b1, pipe_b2;

   int rd_q_a[$], stb_q_a[$], stw_q_a[$], nop_q_a[$], nopw_q_a[$], bfall_q_a[$];
   int rd_q_b[$], stb_q_b[$], stw_q_b[$], bfall_q_b[$];
   logic busy_prev_a = 1'b0;
   logic busy_prev_b = 1'b0;

   command_fifo_sequencer #(.FIFO_READ_LATENCY(1), .CMD_GAP(2)) dut_a (
      .Clk               (clk),
      .reset             (reset),
      .FifoEmpty         (empty_a),
      .FifoDout          (dout_a),
      .Hold              (hold_a),
      .FifoRdEn          (rd_a),
      .CommandFifoReadEn (stb_a),
      .COMMAND_WORD      (word_a),
      .Busy              (busy_a),
      .NopSeen           (nop_a),
`ifdef CMD_SEQ_COUNTER_EN
      .DispatchCount     (cnt_a),
`endif
      .DbgState          (st_a)
   );

   command_fifo_sequencer #(.FIFO_READ_LATENCY(3), .CMD_GAP(0)) dut_b (
      .Clk               (clk),
      .reset             (reset),
      .FifoEmpty         (empty_b),
      .FifoDout          (dout_b),
      .Hold              (hold_b),
      .FifoRdEn          (rd_b),
      .CommandFifoReadEn (stb_b),
      .COMMAND_WORD      (word_b),
      .Busy              (busy_b),
      .NopSeen           (nop_b),
`ifdef CMD_SEQ_COUNTER_EN
      .DispatchCount     (cnt_b),
`endif
      .DbgState          (st_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   // FIFO models: latency 1 for A, latency 3 for B.
   always @(posedge clk) begin
      if (rd_a && fq_a.size() > 0) dout_a <= fq_a.pop_front();
      if (rd_b && fq_b.size() > 0) pipe_b1 <= fq_b.pop_front();
      else                         pipe_b1 <= 16'h0000;
      pipe_b2 <= pipe_b1;
      dout_b  <= pipe_b2;
   end

   // Empty flags follow the queues shortly after each edge.
   always @(posedge clk) begin
      #2;
      empty_a = (fq_a.size() == 0);
      empty_b = (fq_b.size() == 0);
   end

   // Monitor: log events with cycle numbers and check per-cycle invariants.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rd_a) rd_q_a.push_back(cyc);
      if (stb_a) begin stb_q_a.push_back(cyc); stw_q_a.push_back(int'(word_a)); end
      if (nop_a) begin nop_q_a.push_back(cyc); nopw_q_a.push_back(int'(word_a)); end
      if (busy_prev_a && !busy_a) bfall_q_a.push_back(cyc);
      busy_prev_a = busy_a;
      if (rd_b) rd_q_b.push_back(cyc);
      if (stb_b) begin stb_q_b.push_back(cyc); stw_q_b.push_back(int'(word_b)); end
      if (busy_prev_b && !busy_b) bfall_q_b.push_back(cyc);
      busy_prev_b = busy_b;
      check("rd_and_stb_a", {31'b0, rd_a & stb_a}, 32'd0);
      check("rd_and_stb_b", {31'b0, rd_b & stb_b}, 32'd0);
      check("rd_when_empty_a", {31'b0, rd_a & empty_a}, 32'd0);
      check("rd_when_empty_b", {31'b0, rd_b & empty_b}, 32'd0);
      check("rd_during_hold_a", {31'b0, rd_a & hold_a}, 32'd0);
   end

   task automatic clear_a();
      rd_q_a.delete(); stb_q_a.delete(); stw_q_a.delete();
      nop_q_a.delete(); nopw_q_a.delete(); bfall_q_a.delete();
   endtask

   task automatic push_a(input logic [15:0] w);
      fq_a.push_back(w);
      empty_a = 1'b0;
   endtask

   task automatic push_b(input logic [15:0] w);
      fq_b.push_back(w);
      empty_b = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
      empty_a = 1'b1; empty_b = 1'b1;
      dout_a = 16'h0; dout_b = 16'h0; pipe_b1 = 16'h0; pipe_b2 = 16'h0;

      // Reset state, sampled while reset is still held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd", {31'b0, rd_a}, 32'd0);
      check("rst_stb", {31'b0, stb_a}, 32'd0);
      check("rst_busy", {31'b0, busy_a}, 32'd0);
      check("rst_nop", {31'b0, nop_a}, 32'd0);
      check("rst_word", {16'b0, word_a}, 32'h0000);
      check("rst_state", {30'b0, st_a}, 32'd0);
      check("rst_word_b", {16'b0, word_b}, 32'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      run(2);

      // Instance B: latency 3, gap 0, three back-to-back words.
      push_b(16'hB001); push_b(16'hB002); push_b(16'hB003);
      run(25);
      check("b_rd_count", rd_q_b.size(), 3);
      check("b_stb_count", stb_q_b.size(), 3);
      check("b_latency", qget(stb_q_b, 0) - qget(rd_q_b, 0), 4);
      check("b_space1", qget(stb_q_b, 1) - qget(stb_q_b, 0), 5);
      check("b_space2", qget(stb_q_b, 2) - qget(stb_q_b, 1), 5);
      check("b_word0", qget(stw_q_b, 0), 32'hB001);
      check("b_word1", qget(stw_q_b, 1), 32'hB002);
      check("b_word2", qget(stw_q_b, 2), 32'hB003);
      check("b_busy_fall", qget(bfall_q_b, 0) - qget(rd_q_b, 0), 5);

      // Single word.
      clear_a();
      push_a(16'hA0B3);
      run(10);
      check("t1_rd_count", rd_q_a.size(), 1);
      check("t1_stb_count", stb_q_a.size(), 1);
      check("t1_latency", qget(stb_q_a, 0) - qget(rd_q_a, 0), 2);
      check("t1_word", qget(stw_q_a, 0), 32'hA0B3);
      check("t1_busy_fall", qget(bfall_q_a, 0) - qget(rd_q_a, 0), 5);
      check("t1_nop_count", nop_q_a.size(), 0);
      @(negedge clk);
      check("t1_word_held", {16'b0, word_a}, 32'hA0B3);

      // Three back-to-back words.
      clear_a();
      push_a(16'h1111); push_a(16'h2222); push_a(16'h3333);
      run(20);
      check("t2_stb_count", stb_q_a.size(), 3);
      check("t2_space1", qget(stb_q_a, 1) - qget(stb_q_a, 0), 5);
      check("t2_space2", qget(stb_q_a, 2) - qget(stb_q_a, 1), 5);
      check("t2_word0", qget(stw_q_a, 0), 32'h1111);
      check("t2_word1", qget(stw_q_a, 1), 32'h2222);
      check("t2_word2", qget(stw_q_a, 2), 32'h3333);
      check("t2_rd_space", qget(rd_q_a, 1) - qget(rd_q_a, 0), 5);

      // NOP between two real words.
      clear_a();
      push_a(16'h1001); push_a(16'hFFF7); push_a(16'h1002);
      run(20);
      check("t3_rd_count", rd_q_a.size(), 3);
      check("t3_stb_count", stb_q_a.size(), 2);
      check("t3_word0", qget(stw_q_a, 0), 32'h1001);
      check("t3_word1", qget(stw_q_a, 1), 32'h1002);
      check("t3_space", qget(stb_q_a, 1) - qget(stb_q_a, 0), 10);
      check("t3_nop_count", nop_q_a.size(), 1);
      check("t3_nop_time", qget(nop_q_a, 0) - qget(stb_q_a, 0), 5);
      check("t3_nop_word", qget(nopw_q_a, 0), 32'h1001);

      // Hold raised the cycle after the pop of 4444.
      clear_a();
      push_a(16'h4444);
      @(posedge clk); #1;
      hold_a = 1'b1;
      push_a(16'h5555);
      repeat (9) @(posedge clk);
      #1;
      hold_a = 1'b0;
      run(10);
      check("t4_rd_count", rd_q_a.size(), 2);
      check("t4_stb_count", stb_q_a.size(), 2);
      check("t4_latency", qget(stb_q_a, 0) - qget(rd_q_a, 0), 2);
      check("t4_word0", qget(stw_q_a, 0), 32'h4444);
      check("t4_gap_under_hold", qget(bfall_q_a, 0) - qget(rd_q_a, 0), 5);
      check("t4_rd_after_hold", qget(rd_q_a, 1) - qget(rd_q_a, 0), 10);
      check("t4_word1", qget(stw_q_a, 1), 32'h5555);

      // Reset while in WAIT drops the popped word.
      clear_a();
      push_a(16'h6666);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t5_busy", {31'b0, busy_a}, 32'd0);
      check("t5_stb", {31'b0, stb_a}, 32'd0);
      check("t5_nop", {31'b0, nop_a}, 32'd0);
      check("t5_rd", {31'b0, rd_a}, 32'd0);
      check("t5_word", {16'b0, word_a}, 32'h0000);
      check("t5_state", {30'b0, st_a}, 32'd0);
      @(posedge clk); #1;
      push_a(16'h7777);
      run(10);
      check("t5_stb_count", stb_q_a.size(), 1);
      check("t5_word_after", qget(stw_q_a, 0), 32'h7777);
      check("t5_latency", qget(stb_q_a, 0) - qget(rd_q_a, 1), 2);

`ifdef CMD_SEQ_COUNTER_EN
      // Dispatch counter: NOPs excluded, saturates at all-ones.
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_a();
      push_a(16'h0101); push_a(16'hFFF0); push_a(16'h0202); push_a(16'h0303);
      push_a(16'hFFF1); push_a(16'h0404); push_a(16'h0505);
      run(45);
      @(negedge clk);
      check("cnt_five", {16'b0, cnt_a}, 32'd5);
      @(posedge clk); #1;
      force dut_a.dispatch_cnt_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut_a.dispatch_cnt_q;
      push_a(16'h0606); push_a(16'h0707);
      run(15);
      @(negedge clk);
      check("cnt_saturate", {16'b0, cnt_a}, 32'hFFFF);
`endif

      run(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
